// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage vector ASIP pipeline: load-use bubbles, memory freeze, jump flush.
// Optional perf counters (stall_cnt, flush_cnt) are built only when PIPE_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int REG_IDX_W    = 4,
  parameter int LOAD_BUBBLES = 1,
  parameter int MEM_TIMEOUT  = 16,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dec_valid,
  input  logic [REG_IDX_W-1:0] dec_src1,
  input  logic [REG_IDX_W-1:0] dec_src2,
  input  logic                 dec_use1,
  input  logic                 dec_use2,
  input  logic                 dec_vf,
  input  logic                 ex_valid,
  input  logic                 ex_rmem,
  input  logic                 ex_wreg,
  input  logic [REG_IDX_W-1:0] ex_dest,
  input  logic                 ex_vf,
  input  logic                 jmp_take,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 pc_stall,
  output logic                 fd_stall,
  output logic                 dx_stall,
  output logic                 xm_stall,
  output logic                 fd_flush,
  output logic                 dx_flush,
  output logic                 err_timeout,
  output logic [1:0]           state_o,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2
  } state_e;

  localparam int             TMO_W    = $clog2(MEM_TIMEOUT + 1);
  localparam int             BUB_W    = 2;
  localparam logic [BUB_W-1:0] BUB_INIT = BUB_W'(LOAD_BUBBLES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(MEM_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [BUB_W-1:0] BUB_ONE  = BUB_W'(1);

  state_e           state_q, state_d;
  logic [BUB_W-1:0] bub_q, bub_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;

  logic hz;
  logic mw;
  logic wait_hold;
  logic freeze;
  logic bubble;
  logic flush;

  assign hz = dec_valid & ex_valid & ex_rmem & ex_wreg & (ex_vf == dec_vf) &
              ((dec_use1 & (dec_src1 == ex_dest)) | (dec_use2 & (dec_src2 == ex_dest)));
  assign mw = mem_req & ~mem_ready;

  // The freeze continues only while the access is outstanding and the timeout has not expired.
  assign wait_hold = mw & (tmo_q != TMO_MAX);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      bub_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every signal written here gets a default first, otherwise synthesis infers latches.
  always_comb begin
    state_d = state_q;
    bub_d   = bub_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    unique case (state_q)
      ST_RUN: begin
        if (mw) begin
          state_d = ST_MEM_WAIT;
          tmo_d   = TMO_ONE;
        end else if (!jmp_take && hz && (LOAD_BUBBLES > 1)) begin
          state_d = ST_LOAD_STALL;
          bub_d   = BUB_INIT;
        end
      end
      ST_LOAD_STALL: begin
        if (mw) begin
          state_d = ST_MEM_WAIT;
          tmo_d   = TMO_ONE;
        end else begin
          bub_d = bub_q - BUB_ONE;
          if (bub_q == BUB_ONE) state_d = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (wait_hold) begin
          tmo_d = tmo_q + TMO_ONE;
        end else begin
          tmo_d = '0;
          if (mw) err_d = 1'b1;
          // Bubbles interrupted by the wait resume first; otherwise the release cycle acts like RUN.
          if (bub_q != '0) begin
            state_d = ST_LOAD_STALL;
          end else if (!jmp_take && hz && (LOAD_BUBBLES > 1)) begin
            state_d = ST_LOAD_STALL;
            bub_d   = BUB_INIT;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      default: begin
        state_d = ST_RUN;
        bub_d   = '0;
        tmo_d   = '0;
      end
    endcase
  end

  always_comb begin
    freeze = 1'b0;
    bubble = 1'b0;
    flush  = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (mw)            freeze = 1'b1;
        else if (jmp_take) flush  = 1'b1;
        else if (hz)       bubble = 1'b1;
      end
      ST_LOAD_STALL: begin
        if (mw) freeze = 1'b1;
        else    bubble = 1'b1;
      end
      ST_MEM_WAIT: begin
        if (wait_hold) begin
          freeze = 1'b1;
        end else if (bub_q == '0) begin
          if (jmp_take) flush  = 1'b1;
          else if (hz)  bubble = 1'b1;
        end
      end
      default: begin
        freeze = 1'b0;
      end
    endcase
    // Outputs are forced quiet for the whole reset window, not just after the next edge.
    if (rst) begin
      freeze = 1'b0;
      bubble = 1'b0;
      flush  = 1'b0;
    end
  end

  assign pc_stall    = freeze | bubble;
  assign fd_stall    = freeze | bubble;
  assign dx_stall    = freeze;
  assign xm_stall    = freeze;
  assign fd_flush    = flush;
  assign dx_flush    = flush | bubble;
  assign err_timeout = err_q;
  assign state_o     = state_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (fd_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
